// File: rtl/arith_pkg.sv
// Shared arithmetic types: divider FSM states and the divide-by-zero result pattern.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // Fill bit for the quotient on divide by zero; gives an all-ones quotient at any width.
  localparam logic DIV0_QUOT_FILL = 1'b1;

endpackage

// File: rtl/nonrestoring_step.sv
// One combinational non-restoring iteration: shift in a dividend bit, then add or subtract
// the divisor magnitude depending on the sign of the incoming partial remainder.
module nonrestoring_step #(
  parameter int n = 64
) (
  input  logic [n:0]   rem_i,
  input  logic         dvd_bit_i,
  input  logic [n-1:0] dvs_mag_i,
  output logic [n:0]   rem_o,
  output logic         q_bit_o
);

  logic [n:0] shifted;
  logic [n:0] dvs_ext;

  assign shifted = {rem_i[n-1:0], dvd_bit_i};
  assign dvs_ext = {1'b0, dvs_mag_i};
  assign rem_o   = rem_i[n] ? (shifted + dvs_ext) : (shifted - dvs_ext);
  assign q_bit_o = ~rem_o[n];

endmodule

// File: rtl/nonrestoring_divider.sv
// Signed n-bit non-restoring divider: one iteration per cycle on magnitudes,
// sign and remainder correction in FIX, one-cycle done pulse.
//
//   state | meaning
//   IDLE  | waiting for start; captures operands and magnitudes
//   RUN   | n iterations, one per cycle
//   FIX   | remainder restore, sign correction, result registers loaded
//   DONE  | done pulse; a new start is accepted here as in IDLE
module nonrestoring_divider
  import arith_pkg::*;
#(
  parameter int n = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] dividend,
  input  logic [n-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] quotient,
  output logic [n-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(n + 1);

  div_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic [n:0]    rem_q;
  logic [n-1:0]  quot_q;
  logic [n-1:0]  dmag_q;
  logic          neg_quot_q;
  logic          neg_rem_q;
  logic [n-1:0]  quotient_q;
  logic [n-1:0]  remainder_q;
  logic          done_q;
  logic          dz_q;

  logic [n-1:0]  dvd_mag;
  logic [n-1:0]  dvs_mag;
  logic [n:0]    rem_d;
  logic          qbit_d;
  logic [n-1:0]  rem_fix;
  logic [n-1:0]  quot_fix;
  logic [n-1:0]  rem_out;

  assign dvd_mag = dividend[n-1] ? -dividend : dividend;
  assign dvs_mag = divisor[n-1]  ? -divisor  : divisor;

  // The dividend magnitude rides in quot_q and is shifted out MSB-first as quotient bits enter.
  nonrestoring_step #(.n(n)) u_step (
    .rem_i     (rem_q),
    .dvd_bit_i (quot_q[n-1]),
    .dvs_mag_i (dmag_q),
    .rem_o     (rem_d),
    .q_bit_o   (qbit_d)
  );

  // The restored remainder is non-negative and below the divisor, so n bits suffice.
  assign rem_fix  = rem_q[n-1:0] + (rem_q[n] ? dmag_q : '0);
  assign quot_fix = neg_quot_q ? -quot_q : quot_q;
  assign rem_out  = neg_rem_q ? -rem_fix : rem_fix;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quot_q      <= '0;
      dmag_q      <= '0;
      neg_quot_q  <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            dmag_q     <= dvs_mag;
            quot_q     <= dvd_mag;
            rem_q      <= '0;
            neg_quot_q <= dividend[n-1] ^ divisor[n-1];
            neg_rem_q  <= dividend[n-1];
            cnt_q      <= CW'(n);
            if (divisor == '0) begin
              quotient_q  <= {n{DIV0_QUOT_FILL}};
              remainder_q <= dividend;
              dz_q        <= 1'b1;
              done_q      <= 1'b1;
              state_q     <= DONE;
            end else begin
              state_q <= RUN;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          rem_q  <= rem_d;
          quot_q <= {quot_q[n-2:0], qbit_d};
          cnt_q  <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= FIX;
        end
        FIX: begin
          quotient_q  <= quot_fix;
          remainder_q <= rem_out;
          dz_q        <= 1'b0;
          done_q      <= 1'b1;
          state_q     <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dz_q;

endmodule
